// File: rtl/tone_decoder.sv
// Classifies a square-wave tone's half-period as one of eight notes and reports a stable lock.
// Latency: tone_in change sampled at edge k -> edge_p in cycle k+2 -> outputs at k+3.
// Backpressure: none; free-running receiver with registered outputs.
module tone_decoder #(
    parameter int note_C      = 9,
    parameter int note_D      = 8,
    parameter int note_E      = 7,
    parameter int note_F      = 6,
    parameter int note_G      = 5,
    parameter int note_A      = 4,
    parameter int note_AHash  = 3,
    parameter int note_PlusC  = 2,
    parameter int TOL         = 0,
    parameter int MATCH_COUNT = 3,
    parameter int SILENCE     = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tone_in,
    output logic             note_valid,
    output logic [3:0]       note_id,
    output logic             note_strobe,
    output logic [CNT_W-1:0] half_period
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int                MC_W    = $clog2(MATCH_COUNT + 1);
    localparam logic [MC_W-1:0]   MC_LOCK = MC_W'(MATCH_COUNT);
    localparam logic [CNT_W-1:0]  SIL     = CNT_W'(SILENCE);
    localparam logic [31:0]       NOTES [8] = '{32'(note_C), 32'(note_D), 32'(note_E), 32'(note_F),
                                                32'(note_G), 32'(note_A), 32'(note_AHash), 32'(note_PlusC)};

    logic             sync1, sync2, sync3, edge_p;
    logic [CNT_W-1:0] cnt;
    state_t           state, state_nx;
    logic [2:0]       cand_id, cand_id_nx;
    logic [MC_W-1:0]  match_cnt, match_cnt_nx;
    logic             note_valid_nx;
    logic [3:0]       note_id_nx;
    logic             note_strobe_nx;
    logic [CNT_W-1:0] half_period_nx;
    logic             hit;
    logic [2:0]       hit_id;
    logic [31:0]      h_ext;

    // Descending scan so the lowest matching id is the one left standing.
    always_comb begin
        hit    = 1'b0;
        hit_id = 3'd0;
        h_ext  = 32'(cnt);
        for (int i = 7; i >= 0; i--) begin
            if ((h_ext + TOL >= NOTES[i]) && (h_ext <= NOTES[i] + TOL)) begin
                hit    = 1'b1;
                hit_id = 3'(i);
            end
        end
    end

    always_comb begin
        state_nx       = state;
        cand_id_nx     = cand_id;
        match_cnt_nx   = match_cnt;
        note_valid_nx  = note_valid;
        note_id_nx     = note_id;
        note_strobe_nx = 1'b0;
        half_period_nx = half_period;

        if (edge_p) begin
            case (state)
                IDLE: begin
                    state_nx     = MEASURE;
                    match_cnt_nx = '0;
                end
                MEASURE: begin
                    half_period_nx = cnt;
                    if (!hit) begin
                        match_cnt_nx = '0;
                    end else if (hit_id == cand_id) begin
                        match_cnt_nx = match_cnt + 1'b1;
                    end else begin
                        cand_id_nx   = hit_id;
                        match_cnt_nx = MC_W'(1);
                    end
                end
                LOCKED: begin
                    half_period_nx = cnt;
                    if (!(hit && hit_id == cand_id)) begin
                        state_nx      = MEASURE;
                        note_valid_nx = 1'b0;
                        note_id_nx    = 4'hF;
                        if (hit) begin
                            cand_id_nx   = hit_id;
                            match_cnt_nx = MC_W'(1);
                        end else begin
                            match_cnt_nx = '0;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase

            if (state != IDLE && state_nx == MEASURE && hit && match_cnt_nx == MC_LOCK) begin
                state_nx       = LOCKED;
                note_valid_nx  = 1'b1;
                note_id_nx     = {1'b0, cand_id_nx};
                note_strobe_nx = 1'b1;
            end
        end else if (cnt >= SIL) begin
            // An edge landing on the same cycle takes the branch above instead.
            state_nx      = IDLE;
            note_valid_nx = 1'b0;
            note_id_nx    = 4'hF;
            match_cnt_nx  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync3       <= 1'b0;
            edge_p      <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
            cand_id     <= 3'd0;
            match_cnt   <= '0;
            note_valid  <= 1'b0;
            note_id     <= 4'hF;
            note_strobe <= 1'b0;
            half_period <= '0;
        end else begin
            sync1  <= tone_in;
            sync2  <= sync1;
            sync3  <= sync2;
            edge_p <= sync2 ^ sync3;
            if (edge_p) begin
                cnt <= CNT_W'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
            state       <= state_nx;
            cand_id     <= cand_id_nx;
            match_cnt   <= match_cnt_nx;
            note_valid  <= note_valid_nx;
            note_id     <= note_id_nx;
            note_strobe <= note_strobe_nx;
            half_period <= half_period_nx;
        end
    end

endmodule
